decimal_to_bcd_encoder: RTL and testbench

//  Sequential keypad encoder: ten active-high decimal key lines D0..D9 -> 4-bit BCD on A,B,C,D.

---
 rtl/decimal_to_bcd_encoder.sv | 169 ++++++++++++++++
 tb/tb_decimal_to_bcd_encoder.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decimal_to_bcd_encoder.sv
// Debounced ten-key decimal to BCD encoder.
// Emits one valid per press and keeps a short digit history.
module decimal_to_bcd_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int NUM_DIGITS      = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    D0,
    input  logic                    D1,
    input  logic                    D2,
    input  logic                    D3,
    input  logic                    D4,
    input  logic                    D5,
    input  logic                    D6,
    input  logic                    D7,
    input  logic                    D8,
    input  logic                    D9,
    output logic                    A,
    output logic                    B,
    output logic                    C,
    output logic                    D,
    output logic                    valid,
    output logic                    err,
    output logic [4*NUM_DIGITS-1:0] history
);

    localparam int         HW       = 4 * NUM_DIGITS;
    localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        DEBOUNCE,
        HOLD,
        RELEASE
    } state_e;

    logic [9:0]    pins;
    logic [9:0]    sync_q;
    logic [9:0]    s_q;
    logic [9:0]    cand_q;
    state_e        state_q;
    logic [7:0]    cnt_q;
    logic [3:0]    code_q;
    logic          valid_q;
    logic          err_q;
    logic [HW-1:0] hist_q;
    logic [HW-1:0] hist_d;
    logic [3:0]    key_code;
    logic [3:0]    key_ones;
    logic          key_none;
    logic          key_one;
    logic          key_multi;
    logic          same_key;
    logic          cnt_done;

    assign pins = {D9, D8, D7, D6, D5, D4, D3, D2, D1, D0};

    // Two-flop synchroniser for the asynchronous key lines
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            s_q    <= '0;
        end else begin
            sync_q <= pins;
            s_q    <= sync_q;
        end
    end

    // Classify the synchronised keys: none, exactly one, or several
    always_comb begin
        key_code = '0;
        key_ones = '0;
        for (int i = 0; i < 10; i++) begin
            if (s_q[i]) begin
                key_code = 4'(i);
                key_ones = key_ones + 4'd1;
            end
        end
        key_none  = (key_ones == 4'd0);
        key_one   = (key_ones == 4'd1);
        key_multi = (key_ones > 4'd1);
    end

    assign same_key = (s_q == cand_q);
    assign cnt_done = (cnt_q == CNT_LAST);

    // New digit enters the low nibble; the oldest one drops off the top
    generate
        if (NUM_DIGITS == 1) begin : g_hist_one
            assign hist_d = key_code;
        end else begin : g_hist_many
            assign hist_d = {hist_q[HW-5:0], key_code};
        end
    endgenerate

    // Press/release debounce FSM with registered code, valid, err and history
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cand_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            hist_q  <= '0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= key_multi && !clear;
            if (clear) begin
                code_q <= '0;
                hist_q <= '0;
            end
            unique case (state_q)
                IDLE: begin
                    if (key_one) begin
                        cand_q  <= s_q;
                        cnt_q   <= 8'd1;
                        state_q <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    if (!same_key) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else if (cnt_done) begin
                        cnt_q   <= '0;
                        state_q <= HOLD;
                        if (!clear) begin
                            code_q  <= key_code;
                            valid_q <= 1'b1;
                            hist_q  <= hist_d;
                        end
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                HOLD: begin
                    if (key_none) begin
                        cnt_q   <= 8'd1;
                        state_q <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!key_none) begin
                        cnt_q   <= '0;
                        state_q <= HOLD;
                    end else if (cnt_done) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    cnt_q   <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign {D, C, B, A} = code_q;
    assign valid        = valid_q;
    assign err          = err_q;
    assign history      = hist_q;

endmodule

// File: tb/tb_decimal_to_bcd_encoder.sv
// Testbench for decimal_to_bcd_encoder: directed scenarios plus
// randomized key traffic checked against a run-length reference model.
module tb_decimal_to_bcd_encoder;

    localparam int DB = 4;
    localparam int ND = 2;
    localparam int HW = 4 * ND;
    localparam int N  = 1500;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear;
    logic [9:0]    keys;
    logic          A, B, C, D;
    logic          valid;
    logic          err;
    logic [HW-1:0] history;
    logic [3:0]    code;

    int checks = 0;
    int errors = 0;

    logic [9:0] p   [1:N];
    logic [9:0] s   [1:N];
    bit         clr [1:N];
    bit         acc [1:N];

    assign code = {D, C, B, A};

    always #5 clk = ~clk;

    decimal_to_bcd_encoder #(
        .DEBOUNCE_CYCLES(DB),
        .NUM_DIGITS     (ND)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .D0     (keys[0]),
        .D1     (keys[1]),
        .D2     (keys[2]),
        .D3     (keys[3]),
        .D4     (keys[4]),
        .D5     (keys[5]),
        .D6     (keys[6]),
        .D7     (keys[7]),
        .D8     (keys[8]),
        .D9     (keys[9]),
        .A      (A),
        .B      (B),
        .C      (C),
        .D      (D),
        .valid  (valid),
        .err    (err),
        .history(history)
    );

    function automatic logic [3:0] idx(input logic [9:0] v);
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < 10; i++)
            if (v[i]) r = 4'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        keys = '0;
        repeat (DB + 4) step();
    endtask

    task automatic press(input logic [9:0] v, output int nv, output logic [3:0] got);
        keys = v;
        nv   = 0;
        got  = '0;
        repeat (20) begin
            step();
            if (valid) begin
                nv++;
                got = code;
            end
        end
        settle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clear = 1'b0;
        keys  = 10'h020;
        repeat (3) begin
            step();
            checks++;
            if ({code, valid, err, history} !== '0) begin
                errors++;
                $display("FAIL reset_hold: code=%0h valid=%b err=%b hist=%0h, want all 0",
                         code, valid, err, history);
            end
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            step();
            checks++;
            if (valid !== (e == 6)) begin
                errors++;
                $display("FAIL reset_latency: edge %0d valid=%b want %b", e, valid, e == 6);
            end
            if (e == 6) begin
                checks++;
                if (code !== 4'd5 || history[3:0] !== 4'd5) begin
                    errors++;
                    $display("FAIL reset_code: code=%0h hist=%0h want 5", code, history);
                end
            end
        end
        settle();
    endtask

    task automatic test_hold();
        int         nv;
        logic [3:0] last;
        nv   = 0;
        last = 'x;
        keys = 10'h200;
        repeat (50) begin
            step();
            if (valid) begin
                nv++;
                last = code;
            end
        end
        checks++;
        if (nv !== 1 || last !== 4'd9) begin
            errors++;
            $display("FAIL hold_single: valids=%0d code=%0h want 1 and 9", nv, last);
        end
        settle();
        press(10'h001, nv, last);
        checks++;
        if (nv !== 1 || last !== 4'd0) begin
            errors++;
            $display("FAIL second_press: valids=%0d code=%0h want 1 and 0", nv, last);
        end
        checks++;
        if (history !== 8'h90) begin
            errors++;
            $display("FAIL hist_90: hist=%0h want 90", history);
        end
    endtask

    task automatic test_glitch();
        int nv;
        nv   = 0;
        keys = 10'h008;
        repeat (3) begin
            step();
            if (valid) nv++;
        end
        keys = '0;
        step();
        if (valid) nv++;
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL glitch_early: valids=%0d want 0", nv);
        end
        keys = 10'h008;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (valid !== (e == 6)) begin
                errors++;
                $display("FAIL glitch_latency: edge %0d valid=%b want %b", e, valid, e == 6);
            end
            if (e == 6) begin
                checks++;
                if (code !== 4'd3) begin
                    errors++;
                    $display("FAIL glitch_code: code=%0h want 3", code);
                end
            end
        end
        settle();
    endtask

    task automatic test_multi();
        keys = 10'h084;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (err !== (e >= 3) || valid !== 1'b0) begin
                errors++;
                $display("FAIL multi_err: edge %0d err=%b valid=%b want %b and 0",
                         e, err, valid, e >= 3);
            end
        end
        keys = 10'h004;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (err !== (e < 3) || valid !== (e == 6)) begin
                errors++;
                $display("FAIL multi_drop: edge %0d err=%b valid=%b want %b and %b",
                         e, err, valid, e < 3, e == 6);
            end
            if (e == 6) begin
                checks++;
                if (code !== 4'd2) begin
                    errors++;
                    $display("FAIL multi_code: code=%0h want 2", code);
                end
            end
        end
        settle();
    endtask

    task automatic test_history_clear();
        int         nv;
        logic [3:0] got;
        press(10'h002, nv, got);
        press(10'h004, nv, got);
        press(10'h008, nv, got);
        checks++;
        if (history !== 8'h23 || code !== 4'd3) begin
            errors++;
            $display("FAIL hist_23: hist=%0h code=%0h want 23 and 3", history, code);
        end
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (history !== '0 || code !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL clear: hist=%0h code=%0h err=%b want 0", history, code, err);
        end
        keys = 10'h010;
        repeat (5) step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++;
        if (valid !== 1'b0 || code !== '0 || history !== '0) begin
            errors++;
            $display("FAIL clear_accept: valid=%b code=%0h hist=%0h want 0",
                     valid, code, history);
        end
        nv = 0;
        repeat (20) begin
            step();
            if (valid) nv++;
        end
        checks++;
        if (nv !== 0) begin
            errors++;
            $display("FAIL clear_hold: valids=%0d want 0", nv);
        end
        settle();
    endtask

    task automatic test_reset_mid();
        int         nv;
        logic [3:0] got;
        press(10'h002, nv, got);
        keys = 10'h080;
        repeat (4) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (valid !== 1'b0 || code !== '0 || history !== '0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_debounce: valid=%b code=%0h hist=%0h err=%b want 0",
                     valid, code, history, err);
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (valid !== (e == 6)) begin
                errors++;
                $display("FAIL redetect: edge %0d valid=%b want %b", e, valid, e == 6);
            end
            if (e == 6) begin
                checks++;
                if (code !== 4'd7) begin
                    errors++;
                    $display("FAIL redetect_code: code=%0h want 7", code);
                end
            end
        end
        keys = '0;
        repeat (3) step();
        rst_n = 1'b0;
        step();
        checks++;
        if (valid !== 1'b0 || code !== '0 || history !== '0) begin
            errors++;
            $display("FAIL reset_release: valid=%b code=%0h hist=%0h want 0",
                     valid, code, history);
        end
        rst_n = 1'b1;
        keys  = 10'h080;
        for (int e = 1; e <= 8; e++) begin
            step();
            checks++;
            if (valid !== (e == 6)) begin
                errors++;
                $display("FAIL release_redetect: edge %0d valid=%b want %b", e, valid, e == 6);
            end
        end
        settle();
    endtask

    task automatic test_random();
        int            k, len, r, a, b, st, el, es, off;
        bit            armed;
        logic [9:0]    v;
        logic          mvalid, merr;
        logic [3:0]    mcode;
        logic [HW-1:0] mhist;

        k = 1;
        while (k <= N) begin
            r = $urandom_range(0, 9);
            if (r < 4) begin
                v   = '0;
                len = $urandom_range(1, 8);
            end else if (r < 9) begin
                v   = 10'd1 << $urandom_range(0, 9);
                len = $urandom_range(1, 12);
            end else begin
                a   = $urandom_range(0, 9);
                b   = (a + 1 + $urandom_range(0, 8)) % 10;
                v   = (10'd1 << a) | (10'd1 << b);
                len = $urandom_range(1, 5);
            end
            for (int j = 0; j < len && k <= N; j++) begin
                p[k] = v;
                k++;
            end
        end
        for (int i = 1; i <= N; i++) begin
            clr[i] = ($urandom_range(0, 99) == 0);
            s[i]   = (i >= 3) ? p[i-2] : 10'd0;
            acc[i] = 1'b0;
        end

        // Walk runs of constant synchronised input. A one-hot run accepts
        // once DB samples long if the encoder was idle; a rejected short run
        // costs the next run its first sample. DB zeros re-arm after a press.
        armed = 1'b1;
        off   = 0;
        k     = 1;
        while (k <= N) begin
            st = k;
            while (k <= N && s[k] == s[st]) k++;
            len = k - st;
            v   = s[st];
            if (!armed) begin
                off = 0;
                if (v == '0 && len >= DB) armed = 1'b1;
            end else begin
                el  = len - off;
                es  = st + off;
                off = 0;
                if ($countones(v) == 1 && el > 0) begin
                    if (el >= DB) begin
                        acc[es+DB-1] = 1'b1;
                        armed        = 1'b0;
                    end else begin
                        off = 1;
                    end
                end
            end
        end

        keys  = '0;
        clear = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        mcode = '0;
        mhist = '0;
        for (int i = 1; i <= N; i++) begin
            keys  = p[i];
            clear = clr[i];
            step();
            if (clr[i]) begin
                mcode  = '0;
                mhist  = '0;
                mvalid = 1'b0;
            end else if (acc[i]) begin
                mcode  = idx(s[i]);
                mhist  = HW'({mhist, mcode});
                mvalid = 1'b1;
            end else begin
                mvalid = 1'b0;
            end
            merr = !clr[i] && ($countones(s[i]) > 1);
            checks++;
            if (valid !== mvalid) begin
                errors++;
                $display("FAIL rand_valid: cycle %0d valid=%b want %b", i, valid, mvalid);
            end
            checks++;
            if (code !== mcode) begin
                errors++;
                $display("FAIL rand_code: cycle %0d code=%0h want %0h", i, code, mcode);
            end
            checks++;
            if (history !== mhist) begin
                errors++;
                $display("FAIL rand_hist: cycle %0d hist=%0h want %0h", i, history, mhist);
            end
            checks++;
            if (err !== merr) begin
                errors++;
                $display("FAIL rand_err: cycle %0d err=%b want %b", i, err, merr);
            end
        end
        clear = 1'b0;
        settle();
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        keys  = '0;
        test_reset();
        test_hold();
        test_glitch();
        test_multi();
        test_history_clear();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
